// File: rtl/skew_addr_pkg.sv
// Shared definitions for the skewed SRAM read-address generator.
// Holds the two-state FSM encoding, helpers that derive the final counter
// value and the counter width from the run geometry, the lane window
// compare, and the legality check for a parameter set.
package skew_addr_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Counter value of the final beat: the last lane's last offset.
    function automatic int calc_last(input int num_grp, input int grp_skew, input int tile_len);
        return tile_len + (num_grp - 32'sd1) * grp_skew - 32'sd1;
    endfunction

    // Width needed to hold 0..LAST, never narrower than one bit.
    function automatic int calc_cnt_w(input int num_grp, input int grp_skew, input int tile_len);
        int w;
        w = $clog2(calc_last(num_grp, grp_skew, tile_len) + 32'sd1);
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

    // True when lo <= cnt <= lo + len - 1.
    function automatic logic in_window(input int cnt, input int lo, input int len);
        return (cnt >= lo) && (cnt <= lo + len - 32'sd1);
    endfunction

    // Elaboration-time legality of a parameter set.
    function automatic logic params_ok(input int num_grp, input int tile_len,
                                       input int addr_w, input int idle_addr);
        return (num_grp >= 32'sd1) && (tile_len >= 32'sd1) && (idle_addr >= 32'sd0) &&
               (longint'(idle_addr) < (64'sd1 <<< addr_w));
    endfunction

endpackage

// File: rtl/skew_lane.sv
// One address lane of the skewed read-address generator.
// The lane owns a window of the shared step counter starting at
// LANE*GRP_SKEW and TILE_LEN beats long. Inside the window (and while the
// sequencer is running and not stalled) it registers base + offset for both
// the weight and the data SRAM and raises rd_en; otherwise it registers the
// idle pattern.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   run, stall        sequencer running / frozen this cycle
//   cnt               shared step counter
//   base_w, base_d    latched weight/data base addresses
//   addr_w, addr_d    registered lane addresses
//   rd_en             registered lane read enable
module skew_lane
    import skew_addr_pkg::*;
#(
    parameter int LANE      = 32'sd0,
    parameter int GRP_SKEW  = 32'sd4,
    parameter int TILE_LEN  = 32'sd99,
    parameter int ADDR_W    = 32'sd10,
    parameter int IDLE_ADDR = 32'sd127,
    parameter int CNT_W     = 32'sd7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              stall,
    input  logic [CNT_W-1:0]  cnt,
    input  logic [ADDR_W-1:0] base_w,
    input  logic [ADDR_W-1:0] base_d,
    output logic [ADDR_W-1:0] addr_w,
    output logic [ADDR_W-1:0] addr_d,
    output logic              rd_en
);

    localparam int                LO     = LANE * GRP_SKEW;
    localparam logic [ADDR_W-1:0] IDLE_A = ADDR_W'(IDLE_ADDR);

    logic              hit_s;
    logic [ADDR_W-1:0] offset_s;
    logic [ADDR_W-1:0] addr_w_s;
    logic [ADDR_W-1:0] addr_d_s;
    logic [ADDR_W-1:0] addr_w_r;
    logic [ADDR_W-1:0] addr_d_r;
    logic              rd_en_r;

    // Window compare and address arithmetic; sums wrap modulo 2^ADDR_W.
    always_comb begin
        hit_s    = run & ~stall & in_window(int'(cnt), LO, TILE_LEN);
        offset_s = ADDR_W'(int'(cnt) - LO);
        addr_w_s = base_w + offset_s;
        addr_d_s = base_d + offset_s;
    end

    // Lane output registers: a live beat or the idle pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_w_r <= IDLE_A;
            addr_d_r <= IDLE_A;
            rd_en_r  <= 1'b0;
        end else if (hit_s) begin
            addr_w_r <= addr_w_s;
            addr_d_r <= addr_d_s;
            rd_en_r  <= 1'b1;
        end else begin
            addr_w_r <= IDLE_A;
            addr_d_r <= IDLE_A;
            rd_en_r  <= 1'b0;
        end
    end

    assign addr_w = addr_w_r;
    assign addr_d = addr_d_r;
    assign rd_en  = rd_en_r;

endmodule

// File: rtl/skew_addr_gen.sv
// Self-sequenced, skewed SRAM read-address generator for the systolic
// array's weight and data queues. A start pulse in IDLE latches the two base
// addresses and runs a step counter from 0 to LAST; each of NUM_GRP lanes
// reads TILE_LEN consecutive addresses, lane g delayed by g*GRP_SKEW steps.
// stall freezes the counter and blanks every lane for that beat. All outputs
// are registered one cycle behind the counter.
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   start                       run request, honoured only in IDLE
//   stall                       freeze sequencing while high
//   base_w, base_d              weight/data base addresses, latched on start
//   busy                        run in progress (through the done beat)
//   done                        pulse with the final address beat
//   sram_raddr_w, sram_raddr_d  lane g at [g*ADDR_W +: ADDR_W]
//   rd_en                       per-lane read enable, shared by w and d
module skew_addr_gen
    import skew_addr_pkg::*;
#(
    parameter int NUM_GRP   = 32'sd2,
    parameter int GRP_SKEW  = 32'sd4,
    parameter int TILE_LEN  = 32'sd99,
    parameter int ADDR_W    = 32'sd10,
    parameter int IDLE_ADDR = 32'sd127
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stall,
    input  logic [ADDR_W-1:0]         base_w,
    input  logic [ADDR_W-1:0]         base_d,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_GRP*ADDR_W-1:0] sram_raddr_w,
    output logic [NUM_GRP*ADDR_W-1:0] sram_raddr_d,
    output logic [NUM_GRP-1:0]        rd_en
);

    localparam int               LAST   = calc_last(NUM_GRP, GRP_SKEW, TILE_LEN);
    localparam int               CNT_W  = calc_cnt_w(NUM_GRP, GRP_SKEW, TILE_LEN);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LAST);

    if (!params_ok(NUM_GRP, TILE_LEN, ADDR_W, IDLE_ADDR)) begin : g_bad_params
        $error("skew_addr_gen: illegal NUM_GRP/TILE_LEN/IDLE_ADDR");
    end

    logic [0:0]        state_r;
    logic [0:0]        state_next_s;
    logic              last_beat_s;
    logic              run_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] base_w_r;
    logic [ADDR_W-1:0] base_d_r;
    logic              busy_r;
    logic              done_r;

    // Next-state decode; the run ends on the first unstalled cycle at LAST.
    always_comb begin
        state_next_s = state_r;
        last_beat_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!stall && (cnt_r == LAST_C)) begin
                    state_next_s = ST_IDLE;
                    last_beat_s  = 1'b1;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign run_s = (state_r == ST_RUN);

    // FSM, step counter, base latches and the busy/done registers.
    // busy covers the done beat, so it looks at the next state and the
    // final-beat strobe rather than at state_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            base_w_r <= '0;
            base_d_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_RUN) | last_beat_s;
            done_r  <= last_beat_s;
            if (state_r == ST_IDLE) begin
                if (start) begin
                    base_w_r <= base_w;
                    base_d_r <= base_d;
                    cnt_r    <= '0;
                end else begin
                    cnt_r    <= '0;
                end
            end else if (last_beat_s) begin
                cnt_r <= '0;
            end else if (!stall) begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign busy = busy_r;
    assign done = done_r;

    for (genvar g = 0; g < NUM_GRP; g++) begin : g_lane
        skew_lane #(
            .LANE      (g),
            .GRP_SKEW  (GRP_SKEW),
            .TILE_LEN  (TILE_LEN),
            .ADDR_W    (ADDR_W),
            .IDLE_ADDR (IDLE_ADDR),
            .CNT_W     (CNT_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .run    (run_s),
            .stall  (stall),
            .cnt    (cnt_r),
            .base_w (base_w_r),
            .base_d (base_d_r),
            .addr_w (sram_raddr_w[g*ADDR_W +: ADDR_W]),
            .addr_d (sram_raddr_d[g*ADDR_W +: ADDR_W]),
            .rd_en  (rd_en[g])
        );
    end

endmodule

// File: tb/tb_skew_addr_gen.sv
// Bench for skew_addr_gen: a default instance (2 lanes, skew 4, 99 beats)
// and a 4-lane/skew-2/8-beat instance share the stimulus. Every cycle a
// reference model pushes the expected outputs to a queue as stimulus is
// driven; they are popped and compared #1 after the clock edge. A table of
// hand-computed beats plus directed sequences cover stall, back-to-back,
// reset and the 4-lane window.
module tb_skew_addr_gen;

    localparam int AW = 10;

    typedef struct packed {
        logic [3:0]         rd_en;
        logic [3:0][AW-1:0] aw;
        logic [3:0][AW-1:0] ad;
        logic               done;
        logic               busy;
    } exp_t;

    typedef struct {
        bit run;
        int cnt;
        int bw;
        int bd;
    } mstate_t;

    typedef struct {
        int         bw, bd, rel;
        int         w0, d0, w1, d1;
        logic [1:0] en;
        logic       dn, bz;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, start, stall;
    logic [AW-1:0] base_w, base_d;
    logic          busy1, done1, busy2, done2;
    logic [19:0]   raddr_w1, raddr_d1;
    logic [1:0]    rd_en1;
    logic [39:0]   raddr_w2, raddr_d2;
    logic [3:0]    rd_en2;

    int      checks = 0;
    int      errors = 0;
    mstate_t m1 = '{0, 0, 0, 0};
    mstate_t m2 = '{0, 0, 0, 0};
    exp_t    q1[$];
    exp_t    q2[$];

    always #5 clk = ~clk;

    skew_addr_gen dut1 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .base_w(base_w), .base_d(base_d), .busy(busy1), .done(done1),
        .sram_raddr_w(raddr_w1), .sram_raddr_d(raddr_d1), .rd_en(rd_en1)
    );

    skew_addr_gen #(.NUM_GRP(4), .GRP_SKEW(2), .TILE_LEN(8)) dut2 (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .base_w(base_w), .base_d(base_d), .busy(busy2), .done(done2),
        .sram_raddr_w(raddr_w2), .sram_raddr_d(raddr_d2), .rd_en(rd_en2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the beat after this cycle, then advance the model.
    task automatic model_step(input int ng, input int sk, input int tl, inout mstate_t m,
                              input logic r, input logic st, input logic sl,
                              input int bw, input int bd, output exp_t e);
        int last;
        int off;
        last = tl + (ng - 1) * sk - 1;
        e.rd_en = 4'b0000;
        e.done  = 1'b0;
        e.busy  = 1'b0;
        for (int g = 0; g < 4; g++) begin
            e.aw[g] = AW'(127);
            e.ad[g] = AW'(127);
        end
        if (r) begin
            m.run = 0;
            m.cnt = 0;
        end else if (!m.run) begin
            if (st) begin
                m.run = 1; m.cnt = 0; m.bw = bw; m.bd = bd;
                e.busy = 1'b1;
            end
        end else begin
            e.busy = 1'b1;
            if (!sl) begin
                for (int g = 0; g < ng; g++) begin
                    off = m.cnt - g * sk;
                    if (off >= 0 && off < tl) begin
                        e.rd_en[g] = 1'b1;
                        e.aw[g] = AW'((m.bw + off) % (1 << AW));
                        e.ad[g] = AW'((m.bd + off) % (1 << AW));
                    end
                end
                if (m.cnt == last) begin
                    e.done = 1'b1;
                    m.run  = 0;
                end else begin
                    m.cnt++;
                end
            end
        end
    endtask

    // Drive one cycle, push expectations, then pop and compare after the edge.
    task automatic cycle(input logic st, input logic sl, input logic r);
        exp_t e1, e2;
        start = st; stall = sl; rst = r;
        model_step(2, 4, 99, m1, r, st, sl, int'(base_w), int'(base_d), e1);
        q1.push_back(e1);
        model_step(4, 2, 8, m2, r, st, sl, int'(base_w), int'(base_d), e2);
        q2.push_back(e2);
        @(posedge clk);
        #1;
        e1 = q1.pop_front();
        check("d1_rd_en",   64'(rd_en1),   64'(e1.rd_en[1:0]));
        check("d1_done",    64'(done1),    64'(e1.done));
        check("d1_busy",    64'(busy1),    64'(e1.busy));
        check("d1_raddr_w", 64'(raddr_w1), 64'(e1.aw[1:0]));
        check("d1_raddr_d", 64'(raddr_d1), 64'(e1.ad[1:0]));
        e2 = q2.pop_front();
        check("d2_rd_en",   64'(rd_en2),   64'(e2.rd_en));
        check("d2_done",    64'(done2),    64'(e2.done));
        check("d2_busy",    64'(busy2),    64'(e2.busy));
        check("d2_raddr_w", 64'(raddr_w2), 64'(e2.aw));
        check("d2_raddr_d", 64'(raddr_d2), 64'(e2.ad));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy1 !== 1'b0 || busy2 !== 1'b0) && n < 300) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL wait_idle: busy still high after %0d cycles, required 0", n);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t tbl[14];
        int   done_rel, first3, last3, cnt3;

        rst = 1'b1; start = 1'b0; stall = 1'b0;
        base_w = '0; base_d = '0;
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check("reset_rd_en",  64'(rd_en1),   64'(2'b00));
        check("reset_addr_w", 64'(raddr_w1), 64'({10'd127, 10'd127}));
        check("reset_busy",   64'(busy1),    64'(1'b0));
        check("reset_done",   64'(done1),    64'(1'b0));
        cycle(1'b0, 1'b0, 1'b0);

        // Hand-computed beats: {bw, bd, rel, w0, d0, w1, d1, rd_en, done, busy}
        tbl[0]  = '{0, 0, 1, 127, 127, 127, 127, 2'b00, 1'b0, 1'b1};
        tbl[1]  = '{0, 0, 2, 0, 0, 127, 127, 2'b01, 1'b0, 1'b1};
        tbl[2]  = '{0, 0, 5, 3, 3, 127, 127, 2'b01, 1'b0, 1'b1};
        tbl[3]  = '{0, 0, 6, 4, 4, 0, 0, 2'b11, 1'b0, 1'b1};
        tbl[4]  = '{0, 0, 100, 98, 98, 94, 94, 2'b11, 1'b0, 1'b1};
        tbl[5]  = '{0, 0, 101, 127, 127, 95, 95, 2'b10, 1'b0, 1'b1};
        tbl[6]  = '{0, 0, 104, 127, 127, 98, 98, 2'b10, 1'b1, 1'b1};
        tbl[7]  = '{0, 0, 105, 127, 127, 127, 127, 2'b00, 1'b0, 1'b0};
        tbl[8]  = '{1020, 5, 2, 1020, 5, 127, 127, 2'b01, 1'b0, 1'b1};
        tbl[9]  = '{1020, 5, 5, 1023, 8, 127, 127, 2'b01, 1'b0, 1'b1};
        tbl[10] = '{1020, 5, 6, 0, 9, 1020, 5, 2'b11, 1'b0, 1'b1};
        tbl[11] = '{1020, 5, 100, 94, 103, 90, 99, 2'b11, 1'b0, 1'b1};
        tbl[12] = '{1020, 5, 104, 127, 127, 94, 103, 2'b10, 1'b1, 1'b1};
        tbl[13] = '{1023, 1023, 3, 0, 0, 127, 127, 2'b01, 1'b0, 1'b1};

        for (int v = 0; v < 14; v++) begin
            wait_idle();
            base_w = AW'(tbl[v].bw);
            base_d = AW'(tbl[v].bd);
            cycle(1'b1, 1'b0, 1'b0);
            for (int r = 1; r < tbl[v].rel; r++) cycle(1'b0, 1'b0, 1'b0);
            check($sformatf("vec%0d_w0", v), 64'(raddr_w1[9:0]),   64'(tbl[v].w0));
            check($sformatf("vec%0d_d0", v), 64'(raddr_d1[9:0]),   64'(tbl[v].d0));
            check($sformatf("vec%0d_w1", v), 64'(raddr_w1[19:10]), 64'(tbl[v].w1));
            check($sformatf("vec%0d_d1", v), 64'(raddr_d1[19:10]), 64'(tbl[v].d1));
            check($sformatf("vec%0d_en", v), 64'(rd_en1),          64'(tbl[v].en));
            check($sformatf("vec%0d_dn", v), 64'(done1),           64'(tbl[v].dn));
            check($sformatf("vec%0d_bz", v), 64'(busy1),           64'(tbl[v].bz));
        end

        // Stall for 3 cycles right after the cnt=10 beat.
        wait_idle();
        base_w = '0; base_d = '0;
        done_rel = -1;
        for (int i = 0; i < 115; i++) begin
            cycle(i == 0, (i >= 12 && i <= 14), 1'b0);
            if (i + 1 >= 13 && i + 1 <= 15) begin
                check("stall_gap_en", 64'(rd_en1),   64'(2'b00));
                check("stall_gap_w",  64'(raddr_w1), 64'({10'd127, 10'd127}));
            end
            if (i + 1 == 16) begin
                check("stall_resume_l0", 64'(raddr_w1[9:0]),   64'(11));
                check("stall_resume_l1", 64'(raddr_w1[19:10]), 64'(7));
            end
            if (done1 === 1'b1) done_rel = i + 1;
        end
        check("stall_done_rel", 64'(done_rel), 64'(107));

        // Stall on the completing cycle holds done off by one.
        wait_idle();
        done_rel = -1;
        for (int i = 0; i < 110; i++) begin
            cycle(i == 0, i == 103, 1'b0);
            if (i + 1 == 104) check("final_stall_en", 64'(rd_en1), 64'(2'b00));
            if (done1 === 1'b1) done_rel = i + 1;
        end
        check("final_stall_done_rel", 64'(done_rel), 64'(105));

        // start held high: back-to-back runs, new bases only at the next start.
        wait_idle();
        base_w = '0; base_d = '0;
        done_rel = -1;
        for (int i = 0; i < 110; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            base_w = AW'(500); base_d = AW'(600);
            if (i + 1 == 50) check("b2b_first_run_w0", 64'(raddr_w1[9:0]), 64'(48));
            if (i + 1 == 105) begin
                check("b2b_gap_en",   64'(rd_en1), 64'(2'b00));
                check("b2b_gap_busy", 64'(busy1),  64'(1'b1));
            end
            if (i + 1 == 106) begin
                check("b2b_second_w0", 64'(raddr_w1[9:0]), 64'(500));
                check("b2b_second_d0", 64'(raddr_d1[9:0]), 64'(600));
                check("b2b_second_en", 64'(rd_en1),        64'(2'b01));
            end
            if (done1 === 1'b1 && done_rel < 0) done_rel = i + 1;
        end
        check("b2b_first_done_rel", 64'(done_rel), 64'(104));
        start = 1'b0;

        // Reset at cnt=50 aborts with no done; a new start begins at offset 0.
        wait_idle();
        base_w = '0; base_d = '0;
        done_rel = -1;
        for (int i = 0; i < 60; i++) begin
            cycle(i == 0, 1'b0, i == 51);
            if (i + 1 == 52) begin
                check("rst_mid_en",   64'(rd_en1),   64'(2'b00));
                check("rst_mid_w",    64'(raddr_w1), 64'({10'd127, 10'd127}));
                check("rst_mid_busy", 64'(busy1),    64'(1'b0));
            end
            if (i + 1 >= 52 && done1 === 1'b1) done_rel = i + 1;
        end
        check("rst_no_done", 64'(done_rel), 64'(-1));
        base_w = AW'(3); base_d = AW'(4);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("rst_restart_w0", 64'(raddr_w1[9:0]), 64'(3));
        check("rst_restart_d0", 64'(raddr_d1[9:0]), 64'(4));

        // 4-lane instance: lane3 window is cnt 6..13, beats at rel 8..15.
        wait_idle();
        base_w = '0; base_d = '0;
        first3 = -1; last3 = -1; cnt3 = 0; done_rel = -1;
        for (int i = 0; i < 20; i++) begin
            cycle(i == 0, 1'b0, 1'b0);
            if (rd_en2[3] === 1'b1) begin
                if (first3 < 0) first3 = i + 1;
                last3 = i + 1;
                cnt3++;
            end
            if (done2 === 1'b1) done_rel = i + 1;
        end
        check("g4_lane3_beats", 64'(cnt3),     64'(8));
        check("g4_lane3_first", 64'(first3),   64'(8));
        check("g4_lane3_last",  64'(last3),    64'(15));
        check("g4_done_rel",    64'(done_rel), 64'(15));

        wait_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
